// File: rtl/wbtl_pkg.sv
// rtl/wbtl_pkg.sv - shared register map, bit positions and ack FSM state for the Wishbone/serial-TL bridge
package wbtl_pkg;

    // Register offsets within the 16-byte window (address bits [1:0] are don't-care)
    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_RXDATA = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    // STATUS bit positions
    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_FULL     = 2;
    localparam int ST_RX_EMPTY    = 3;
    localparam int ST_TX_OVERFLOW = 4;
    localparam int ST_RX_UNDERFLW = 5;
    localparam int ST_TX_CNT_LSB  = 8;
    localparam int ST_RX_CNT_LSB  = 16;

    // CTRL bit positions
    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_FLAGS = 1;
    localparam int CTRL_IRQ_EN    = 2;

    // Wishbone ack FSM
    typedef enum logic {
        ACK_IDLE = 1'b0,
        ACK_RESP = 1'b1
    } ack_state_t;

endpackage

// File: rtl/wbtl_fifo.sv
// rtl/wbtl_fifo.sv - synchronous FIFO with push, pop, flush, full, empty and occupancy count
module wbtl_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored here,
    // so callers only need to raise the request.
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and count update; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_serial_tl_bridge.sv
// rtl/wb_serial_tl_bridge.sv - Wishbone register window bridging to serial TileLink beat streams (optional IRQ: WBTL_IRQ_EN)
module wb_serial_tl_bridge
    import wbtl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tl_in_valid,
    input  logic        tl_in_ready,
    output logic [31:0] tl_in_bits,
    input  logic        tl_out_valid,
    output logic        tl_out_ready,
    input  logic [31:0] tl_out_bits,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ack_state_t  state;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        tx_overflow;
    logic        rx_underflow;

    logic        req;
    logic        hit;
    logic [3:0]  off;
    logic        wr_tx;
    logic        rd_rx;
    logic        wr_ctrl;
    logic        flush;
    logic        clr_flags;

    logic        tx_full;
    logic        tx_empty;
    logic [CW-1:0] tx_count;
    logic        tx_pop;

    logic        rx_full;
    logic        rx_empty;
    logic [CW-1:0] rx_count;
    logic [31:0] rx_head;
    logic        rx_push;
    logic        rx_pop;

    logic [31:0] status;
    logic [31:0] rdata;

    // Byte lanes and sub-word address bits carry no meaning: every access is a full word
    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // An access is taken only on the IDLE->RESP edge; all side effects hang off req
    assign req       = wbs_cyc_i & wbs_stb_i & (state == ACK_IDLE);
    assign hit       = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign off       = {wbs_adr_i[3:2], 2'b00};
    assign wr_tx     = req & hit &  wbs_we_i & (off == OFF_TXDATA);
    assign rd_rx     = req & hit & ~wbs_we_i & (off == OFF_RXDATA);
    assign wr_ctrl   = req & hit &  wbs_we_i & (off == OFF_CTRL);
    assign flush     = wr_ctrl & wbs_dat_i[CTRL_FLUSH];
    assign clr_flags = wr_ctrl & (wbs_dat_i[CTRL_FLUSH] | wbs_dat_i[CTRL_CLR_FLAGS]);

    assign tl_in_valid  = ~tx_empty;
    assign tx_pop       = tl_in_valid & tl_in_ready;
    assign tl_out_ready = ~rx_full;
    assign rx_push      = tl_out_valid & tl_out_ready;
    assign rx_pop       = rd_rx & ~rx_empty;

    wbtl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (flush),
        .push      (wr_tx),
        .push_data (wbs_dat_i),
        .pop       (tx_pop),
        .pop_data  (tl_in_bits),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    wbtl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_rx_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (flush),
        .push      (rx_push),
        .push_data (tl_out_bits),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // STATUS word assembly; counts are zero-extended into their 8-bit fields
    always_comb begin
        status                          = '0;
        status[ST_TX_FULL]              = tx_full;
        status[ST_TX_EMPTY]             = tx_empty;
        status[ST_RX_FULL]              = rx_full;
        status[ST_RX_EMPTY]             = rx_empty;
        status[ST_TX_OVERFLOW]          = tx_overflow;
        status[ST_RX_UNDERFLW]          = rx_underflow;
        status[ST_TX_CNT_LSB +: 8]      = 8'(tx_count);
        status[ST_RX_CNT_LSB +: 8]      = 8'(rx_count);
    end

    // Read mux: only in-window reads of readable offsets return non-zero data
    always_comb begin
        rdata = '0;
        if (hit && !wbs_we_i) begin
            case (off)
                OFF_RXDATA: rdata = rx_empty ? 32'h0 : rx_head;
                OFF_STATUS: rdata = status;
                default:    rdata = '0;
            endcase
        end
    end

    // Ack FSM with registered ack/data so read data lines up exactly with the ack cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ACK_IDLE;
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            case (state)
                ACK_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        state <= ACK_RESP;
                        ack_q <= 1'b1;
                        dat_q <= rdata;
                    end else begin
                        ack_q <= 1'b0;
                        dat_q <= '0;
                    end
                end
                default: begin
                    state <= ACK_IDLE;
                    ack_q <= 1'b0;
                    dat_q <= '0;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // Sticky error flags; fullness/emptiness is judged before any same-cycle serial pop or push
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else if (clr_flags) begin
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            if (wr_tx && tx_full) begin
                tx_overflow <= 1'b1;
            end
            if (rd_rx && rx_empty) begin
                rx_underflow <= 1'b1;
            end
        end
    end

`ifdef WBTL_IRQ_EN
    logic irq_enable;
    logic irq_q;

    // Interrupt enable bit from CTRL
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_enable <= 1'b0;
        end else if (wr_ctrl) begin
            irq_enable <= wbs_dat_i[CTRL_IRQ_EN];
        end
    end

    // Registered interrupt: pending RX data or any sticky error, when enabled
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_enable & (~rx_empty | tx_overflow | rx_underflow);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_serial_tl_bridge.sv
// tb/tb_wb_serial_tl_bridge.sv - directed self-checking bench for wb_serial_tl_bridge
module tb_wb_serial_tl_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rdat;
    logic        in_valid, in_ready;
    logic [31:0] in_bits;
    logic        out_valid, out_ready;
    logic [31:0] out_bits;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_serial_tl_bridge #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_sel_i    (sel),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .tl_in_valid  (in_valid),
        .tl_in_ready  (in_ready),
        .tl_in_bits   (in_bits),
        .tl_out_valid (out_valid),
        .tl_out_ready (out_ready),
        .tl_out_bits  (out_bits),
        .irq_o        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One Wishbone access; ack must arrive within a small cycle budget
    task automatic wb(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] r);
        bit got;
        got = 0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (ack === 1'b1) got = 1;
        end
        r = rdat;
        chk({tag, " ack"}, {31'b0, got}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb(tag, 1'b1, a, d, r);
        chk({tag, " wdata0"}, r, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb(tag, 1'b0, a, 32'h0, r);
        chk(tag, r, exp);
    endtask

    task automatic beat(input logic [31:0] d);
        out_valid = 1'b1; out_bits = d;
        tick();
        out_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 4'hF;
        in_ready = 1'b0; out_valid = 1'b0; out_bits = 0;

        // Reset state
        tick(); tick();
        chk("rst ack", {31'b0, ack}, 32'd0);
        chk("rst dat", rdat, 32'h0);
        chk("rst in_valid", {31'b0, in_valid}, 32'd0);
        chk("rst irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post-rst out_ready", {31'b0, out_ready}, 32'd1);
        rd("rst status", BASE + 32'h8, 32'h0000_000A);

        // Single TX write, drained immediately; byte selects ignored
        in_ready = 1'b1;
        sel = 4'h1;
        wr("tx1", BASE + 32'h0, 32'h1234_5678);
        chk("tx1 in_valid", {31'b0, in_valid}, 32'd1);
        chk("tx1 in_bits", in_bits, 32'h1234_5678);
        tick();
        chk("tx1 in_valid drop", {31'b0, in_valid}, 32'd0);
        rd("tx1 status", BASE + 32'h8, 32'h0000_000A);

        // TX overflow: 9 writes into depth 8 with the sink stalled
        in_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr("txfill", BASE, 32'h100 + i);
        rd("txovf status", BASE + 32'h8, 32'h0000_0819);
        in_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("txdrain bits", in_bits, 32'h100 + i);
            tick();
        end
        chk("txdrain empty", {31'b0, in_valid}, 32'd0);
        wr("clr", BASE + 32'hC, 32'h2);
        rd("clr status", BASE + 32'h8, 32'h0000_000A);

        // RX reads including underflow
        beat(32'hA);
        beat(32'hB);
        rd("rx0", BASE + 32'h4, 32'hA);
        rd("rx1", BASE + 32'h4, 32'hB);
        rd("rx2 empty", BASE + 32'h4, 32'h0);
        tick();
        chk("dat idle", rdat, 32'h0);
        rd("rxudf status", BASE + 32'h8, 32'h0000_002A);
        wr("clr2", BASE + 32'hC, 32'h2);
        rd("clr2 status", BASE + 32'h8, 32'h0000_000A);

        // RX full back-pressure
        for (int i = 0; i < 8; i++) beat(32'h200 + i);
        chk("rxfull out_ready", {31'b0, out_ready}, 32'd0);
        rd("rxfull status", BASE + 32'h8, 32'h0008_0006);
        rd("rxfull head", BASE + 32'h4, 32'h200);
        chk("rxfull ready back", {31'b0, out_ready}, 32'd1);
        rd("rx7 status", BASE + 32'h8, 32'h0007_0002);
        wr("flush", BASE + 32'hC, 32'h1);
        rd("flush status", BASE + 32'h8, 32'h0000_000A);

        // Flush in the same cycle as a serial beat: the beat is lost
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'hC; wdat = 32'h1;
        out_valid = 1'b1; out_bits = 32'hDEAD_BEEF;
        tick();
        chk("flushbeat ack", {31'b0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; out_valid = 1'b0;
        rd("flushbeat status", BASE + 32'h8, 32'h0000_000A);

        // Out-of-window and read-only/write-only offsets
        in_ready = 1'b0;
        wr("oow write", BASE + 32'h100, 32'h55);
        wr("ro write", BASE + 32'h8, 32'hFFFF_FFFF);
        rd("oow status", BASE + 32'h8, 32'h0000_000A);
        beat(32'h77);
        rd("oow read", 32'h2000_0004, 32'h0);
        wr("rxdata write", BASE + 32'h4, 32'h99);
        rd("txdata read", BASE + 32'h0, 32'h0);
        rd("oow rx kept", BASE + 32'h8, 32'h0001_0002);

`ifdef WBTL_IRQ_EN
        wr("irq en", BASE + 32'hC, 32'h5);
        tick();
        chk("irq flushed", {31'b0, irq}, 32'd0);
        out_valid = 1'b1; out_bits = 32'h33;
        tick();
        out_valid = 1'b0;
        chk("irq lat0", {31'b0, irq}, 32'd0);
        tick();
        chk("irq set", {31'b0, irq}, 32'd1);
        rd("irq rx", BASE + 32'h4, 32'h33);
        tick();
        chk("irq clear", {31'b0, irq}, 32'd0);
`else
        wr("irq en", BASE + 32'hC, 32'h5);
        beat(32'h33);
        tick();
        chk("irq tied", {31'b0, irq}, 32'd0);
        rd("irq rx", BASE + 32'h4, 32'h33);
`endif

        // Reset during an access: abandoned with no ack, FIFOs emptied
        wr("pre-rst tx", BASE, 32'h77);
        chk("pre-rst in_valid", {31'b0, in_valid}, 32'd1);
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h8;
        rst = 1'b1;
        tick();
        chk("inflight ack", {31'b0, ack}, 32'd0);
        chk("inflight dat", rdat, 32'h0);
        chk("inflight in_valid", {31'b0, in_valid}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post ack", {31'b0, ack}, 32'd0);
        chk("post out_ready", {31'b0, out_ready}, 32'd1);
        rd("post status", BASE + 32'h8, 32'h0000_000A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_serial_tl_bridge.md
WB_SERIAL_TL_BRIDGE -- requirements
Module: wb_serial_tl_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, register window base; bits [3:0] ignored.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per FIFO; power of two, 2..128.
REQ-003 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe and write-enable.
REQ-006 SHALL have ports wbs_adr_i  in  32, wbs_dat_i  in  32, wbs_sel_i  in  4  Wishbone address, write data and byte select.
REQ-007 SHALL have ports wbs_ack_o  out  1 and wbs_dat_o  out  32  Wishbone acknowledge and read data.
REQ-008 SHALL have ports tl_in_valid  out  1, tl_in_ready  in  1, tl_in_bits  out  32  host-to-chip serial TileLink beats.
REQ-009 SHALL have ports tl_out_valid  in  1, tl_out_ready  out  1, tl_out_bits  in  32  chip-to-host serial TileLink beats.
REQ-010 SHALL have port irq_o  out  1  interrupt request.

Function
REQ-011 SHALL decode offsets in the BASE_ADDR window as 0x0 TXDATA (write-only), 0x4 RXDATA (read-only), 0x8 STATUS (read-only), 0xC CTRL (write-only).
REQ-012 SHALL ignore wbs_sel_i; every access is a full 32-bit access.
REQ-013 SHALL run a two-state ack FSM: IDLE to ACK when cyc&stb; ACK drives wbs_ack_o=1 for exactly one cycle and then returns to IDLE; access side effects occur on the IDLE-to-ACK edge.
REQ-014 SHALL ack an access outside the window, or a write to a read-only offset, with wbs_dat_o=0 and no side effect.
REQ-015 SHALL push wbs_dat_i into the TX FIFO on a TXDATA write when the FIFO is not full; when the FIFO is full, the write SHALL be acked, the data dropped, and the sticky tx_overflow flag set, even if a pop occurs in the same cycle.
REQ-016 SHALL drive tl_in_valid = TX FIFO not empty and tl_in_bits = TX head, and SHALL pop the TX FIFO on tl_in_valid&tl_in_ready.
REQ-017 SHALL drive tl_out_ready = RX FIFO not full, and SHALL push tl_out_bits on tl_out_valid&tl_out_ready.
REQ-018 SHALL, on an RXDATA read, return the RX head and pop it; when the RX FIFO is empty, the read SHALL return 0 and set the sticky rx_underflow flag.
REQ-019 SHALL, on an RXDATA read, present the read data on wbs_dat_o in the same cycle that wbs_ack_o is asserted, and hold wbs_dat_o at 0 in all other cycles.
REQ-020 SHALL map STATUS as: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_overflow, [5] rx_underflow, [15:8] tx_count, [23:16] rx_count; all other bits read 0.
REQ-021 SHALL decode CTRL as: bit0 flushes both FIFOs and clears both sticky flags; bit1 clears the sticky flags only; bit2 is irq_enable.
REQ-022 SHALL give a flush priority over a same-cycle serial-side push or pop, and SHALL discard that beat.
REQ-023 SHALL let simultaneous push and pop on a non-full, non-empty FIFO leave its count unchanged.
REQ-024 SHALL wrap FIFO pointers modulo FIFO_DEPTH; counts SHALL span 0..FIFO_DEPTH.

Reset
REQ-025 SHALL, on wb_rst_i, empty both FIFOs, clear both sticky flags and irq_enable, and put the ack FSM in IDLE.
REQ-026 SHALL, during and after reset, output wbs_ack_o=0, wbs_dat_o=0, tl_in_valid=0, tl_out_ready=1 (once reset is released) and irq_o=0.
REQ-027 SHALL abandon a Wishbone access in flight when reset is asserted, with no ack.

Configuration
REQ-028 SHALL, with WBTL_IRQ_EN defined, drive irq_o = irq_enable & (RX not empty | tx_overflow | rx_underflow), registered with one cycle of latency.
REQ-029 SHALL, without WBTL_IRQ_EN, tie irq_o to 0, make CTRL bit2 writes have no effect, and have no irq_enable flop.

Structure
REQ-030 SHALL take register offsets, STATUS and CTRL bit positions, and the ack FSM state enum from the shared package wbtl_pkg.
REQ-031 SHALL instantiate the sub-module wbtl_fifo (synchronous FIFO with push, pop, flush, full, empty, count) twice: once for TX and once for RX.

Verification
REQ-032 SHALL cover: write 0x1234_5678 to TXDATA with tl_in_ready=1 -> tl_in_bits=0x1234_5678 and tl_in_valid=1 for one cycle; STATUS[1]=1 afterwards.
REQ-033 SHALL cover: tl_in_ready=0 and 9 TXDATA writes at FIFO_DEPTH=8 -> 8 retained, STATUS[4]=1, STATUS[15:8]=8, all 9 writes acked.
REQ-034 SHALL cover: push beats 0xA, 0xB via tl_out, then 3 RXDATA reads -> returns 0xA, 0xB, 0; STATUS[5]=1.
REQ-035 SHALL cover: 8 RX beats at depth 8 -> tl_out_ready=0; one RXDATA read -> tl_out_ready=1 in the following cycle.
REQ-036 SHALL cover: a CTRL=0x1 write in the same cycle as a tl_out beat -> STATUS=0x0000_000A, the beat lost.
REQ-037 SHALL cover: with WBTL_IRQ_EN defined and CTRL=0x4, one RX beat -> irq_o=1 one cycle later; an RXDATA read -> irq_o=0.
